// File: rtl/mt_pkg.sv
// mt_pkg: definitions shared by the multithreading front end.
//   THREAD_POOL_SIZE : default number of hardware threads
//   TID_W            : thread-ID width for thread-tagged pipeline registers
//   thread_state_t   : per-thread scheduling state
package mt_pkg;

  localparam int THREAD_POOL_SIZE = 4;
  localparam int TID_W            = $clog2(THREAD_POOL_SIZE);

  typedef enum logic [1:0] {
    T_DISABLED = 2'd0,
    T_READY    = 2'd1,
    T_WAITING  = 2'd2
  } thread_state_t;

endpackage

// File: rtl/thread_scheduler_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req       in  N      per-thread request flags
//   ptr       in  TID_W  last-served thread; the scan starts at ptr+1
//   gnt_valid out 1      some request was found
//   gnt_tid   out TID_W  first requester in the order ptr+1, ptr+2, ... mod N
module rr_pick #(
  parameter int N     = 4,
  parameter int TID_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [TID_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [TID_W-1:0] gnt_tid
);

  logic [TID_W-1:0] idx;

  // Scan from the farthest slot back to the nearest so the nearest
  // requester after ptr is the last (winning) assignment.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_tid   = '0;
    idx       = '0;
    for (int k = N; k >= 1; k--) begin
      idx = TID_W'((int'(ptr) + k) % N);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_tid   = idx;
      end
    end
  end

endmodule

// File: rtl/thread_scheduler.sv
// thread_scheduler: stall-aware round-robin thread selector ahead of fetch.
//   clk, rst_n     clock / async active-low reset
//   thread_en      per-thread enable mask
//   block_*        block request: tid and length (0 = until wake)
//   wake_*         wake request for a WAITING thread
//   fetch_ready    fetch accepts the current offer
//   fetch_valid    registered offer valid
//   TID_fetch      registered offered thread ID
//   ready_mask     per-thread READY flags
//
// Per-thread state | meaning
//   T_DISABLED     | thread_en low; never offered
//   T_READY        | eligible for selection
//   T_WAITING      | blocked; leaves on timer reaching 1 or on wake
module thread_scheduler #(
  parameter int THREAD_POOL_SIZE = mt_pkg::THREAD_POOL_SIZE,
  parameter int TID_W            = $clog2(THREAD_POOL_SIZE),
  parameter int CNT_W            = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [THREAD_POOL_SIZE-1:0] thread_en,
  input  logic                        block_valid,
  input  logic [TID_W-1:0]            block_tid,
  input  logic [CNT_W-1:0]            block_cycles,
  input  logic                        wake_valid,
  input  logic [TID_W-1:0]            wake_tid,
  input  logic                        fetch_ready,
  output logic                        fetch_valid,
  output logic [TID_W-1:0]            TID_fetch,
  output logic [THREAD_POOL_SIZE-1:0] ready_mask
);

  import mt_pkg::thread_state_t;
  import mt_pkg::T_DISABLED;
  import mt_pkg::T_READY;
  import mt_pkg::T_WAITING;

  localparam int N = THREAD_POOL_SIZE;

  logic             handshake;
  logic             kill;
  logic [TID_W-1:0] rr_ptr;
  logic [TID_W-1:0] pick_ptr;
  logic [N-1:0]     req;
  logic             gnt_valid;
  logic [TID_W-1:0] gnt_tid;

  for (genvar i = 0; i < N; i++) begin : g_thread
    thread_state_t    st;
    logic [CNT_W-1:0] tmr;
    logic             blk;
    logic             wak;

    // Out-of-range tids never match any i, so they are ignored here.
    assign blk = block_valid && (block_tid == TID_W'(i));
    assign wak = wake_valid  && (wake_tid  == TID_W'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st  <= T_DISABLED;
        tmr <= '0;
      end else if (!thread_en[i]) begin
        st  <= T_DISABLED;
        tmr <= '0;
      end else begin
        case (st)
          T_DISABLED: begin
            st  <= T_READY;
            tmr <= '0;
          end
          T_READY: begin
            if (blk) begin
              st  <= T_WAITING;
              tmr <= block_cycles;
            end
          end
          T_WAITING: begin
            if (blk) begin
              tmr <= block_cycles;
            end else if (wak) begin
              st  <= T_READY;
              tmr <= '0;
            end else if (tmr > CNT_W'(1)) begin
              tmr <= tmr - CNT_W'(1);
            end else if (tmr == CNT_W'(1)) begin
              st  <= T_READY;
              tmr <= '0;
            end
          end
          default: begin
            st  <= T_DISABLED;
            tmr <= '0;
          end
        endcase
      end
    end

    assign ready_mask[i] = (st == T_READY);
    // A thread being blocked or disabled this cycle must not win this edge.
    assign req[i] = (st == T_READY) && thread_en[i] && !blk;
  end

  assign handshake = fetch_valid && fetch_ready;

  // A stalled offer is withdrawn if its thread is blocked or disabled.
  assign kill = fetch_valid && !fetch_ready &&
                ((block_valid && (block_tid == TID_fetch)) || !thread_en[TID_fetch]);

  // On handshake the scan continues after the thread just issued.
  assign pick_ptr = handshake ? TID_fetch : rr_ptr;

  rr_pick #(
    .N     (N),
    .TID_W (TID_W)
  ) u_pick (
    .req       (req),
    .ptr       (pick_ptr),
    .gnt_valid (gnt_valid),
    .gnt_tid   (gnt_tid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      TID_fetch   <= '0;
      rr_ptr      <= TID_W'(N - 1);
    end else begin
      if (handshake) begin
        rr_ptr <= TID_fetch;
      end
      if (kill) begin
        fetch_valid <= 1'b0;
      end else if (!fetch_valid || fetch_ready) begin
        fetch_valid <= gnt_valid;
        if (gnt_valid) begin
          TID_fetch <= gnt_tid;
        end
      end
    end
  end

endmodule

// File: tb/tb_thread_scheduler.sv
// tb_thread_scheduler: directed scenarios with a scoreboard of expected
// issue order; monitors pop on every accepted offer.
module tb_thread_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] thread_en;
  logic       block_valid;
  logic [1:0] block_tid;
  logic [5:0] block_cycles;
  logic       wake_valid;
  logic [1:0] wake_tid;
  logic       fetch_ready;
  logic       fetch_valid;
  logic [1:0] TID_fetch;
  logic [3:0] ready_mask;

  logic [2:0] thread_en3;
  logic       block_valid3;
  logic [1:0] block_tid3;
  logic       fetch_valid3;
  logic [1:0] TID_fetch3;
  logic [2:0] ready_mask3;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int exp_q3[$];
  int mon_e;
  int mon_e3;

  always #5 clk = ~clk;

  thread_scheduler #(.THREAD_POOL_SIZE(4), .TID_W(2), .CNT_W(6)) u_dut (
    .clk(clk), .rst_n(rst_n), .thread_en(thread_en),
    .block_valid(block_valid), .block_tid(block_tid), .block_cycles(block_cycles),
    .wake_valid(wake_valid), .wake_tid(wake_tid), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .TID_fetch(TID_fetch), .ready_mask(ready_mask)
  );

  thread_scheduler #(.THREAD_POOL_SIZE(3), .TID_W(2), .CNT_W(6)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .thread_en(thread_en3),
    .block_valid(block_valid3), .block_tid(block_tid3), .block_cycles(block_cycles),
    .wake_valid(wake_valid), .wake_tid(wake_tid), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid3), .TID_fetch(TID_fetch3), .ready_mask(ready_mask3)
  );

  always @(negedge clk) begin
    if (rst_n && fetch_valid && fetch_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL issue4: got tid %0d, expected no issue", TID_fetch);
      end else begin
        mon_e = exp_q.pop_front();
        if (int'(TID_fetch) != mon_e) begin
          n_fail++;
          $display("FAIL issue4: got tid %0d, expected %0d at %0t", TID_fetch, mon_e, $time);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && fetch_valid3 && fetch_ready) begin
      n_checks++;
      if (exp_q3.size() == 0) begin
        n_fail++;
        $display("FAIL issue3: got tid %0d, expected no issue", TID_fetch3);
      end else begin
        mon_e3 = exp_q3.pop_front();
        if (int'(TID_fetch3) != mon_e3) begin
          n_fail++;
          $display("FAIL issue3: got tid %0d, expected %0d at %0t", TID_fetch3, mon_e3, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    thread_en    = 4'b0000;
    thread_en3   = 3'b000;
    block_valid  = 1'b0;
    block_tid    = 2'd0;
    block_valid3 = 1'b0;
    block_tid3   = 2'd0;
    block_cycles = 6'd0;
    wake_valid   = 1'b0;
    wake_tid     = 2'd0;
    fetch_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic finish_scn(input string name);
    @(negedge clk);
    #1;
    chk({name, " drained4"}, exp_q.size(), 0);
    chk({name, " drained3"}, exp_q3.size(), 0);
    do_reset();
  endtask

  task automatic block(input int tid, input int cyc);
    block_valid  = 1'b1;
    block_tid    = 2'(tid);
    block_cycles = 6'(cyc);
  endtask

  initial begin
    do_reset();
    chk("reset fetch_valid", int'(fetch_valid), 0);
    chk("reset TID_fetch", int'(TID_fetch), 0);
    chk("reset ready_mask", int'(ready_mask), 0);
    chk("reset3 fetch_valid", int'(fetch_valid3), 0);

    // Scenario 1: full rotation, plus an N=3 instance with an out-of-range block.
    thread_en  = 4'b1111;
    thread_en3 = 3'b111;
    exp_q  = {0, 1, 2, 3, 0, 1, 2, 3};
    exp_q3 = {0, 1, 2, 0, 1, 2, 0, 1};
    edges(1);
    chk("s1 mask after e1", int'(ready_mask), 15);
    chk("s1 no offer at e1", int'(fetch_valid), 0);
    chk("s1 mask3 after e1", int'(ready_mask3), 7);
    edges(2);
    block_valid3 = 1'b1;
    block_tid3   = 2'd3;
    block_cycles = 6'd5;
    edges(1);
    block_valid3 = 1'b0;
    chk("s1 oor block ignored", int'(ready_mask3), 7);
    edges(5);
    finish_scn("s1");

    // Scenario 2: timed block of tid 1 for 3 cycles.
    thread_en = 4'b1111;
    exp_q = {0, 1, 2, 3, 0, 2, 3, 0, 1, 2, 3, 0};
    edges(4);
    block(1, 3);
    edges(1);
    block_valid = 1'b0;
    chk("s2 mask blocked", int'(ready_mask), 13);
    edges(2);
    chk("s2 mask still blocked", int'(ready_mask), 13);
    edges(1);
    chk("s2 mask resumed", int'(ready_mask), 15);
    edges(5);
    finish_scn("s2");

    // Scenario 3: block-until-wake, wake, then same-cycle block+wake.
    thread_en = 4'b1111;
    exp_q = {0, 1, 3, 0, 1, 3, 0, 1, 2, 3, 0, 1, 3, 0};
    edges(1);
    block(2, 0);
    edges(1);
    block_valid = 1'b0;
    chk("s3 mask waiting", int'(ready_mask), 11);
    edges(5);
    wake_valid = 1'b1;
    wake_tid   = 2'd2;
    edges(1);
    wake_valid = 1'b0;
    chk("s3 mask woken", int'(ready_mask), 15);
    edges(2);
    block(2, 0);
    wake_valid = 1'b1;
    wake_tid   = 2'd2;
    edges(1);
    block_valid = 1'b0;
    wake_valid  = 1'b0;
    chk("s3 block beats wake", int'(ready_mask), 11);
    edges(4);
    finish_scn("s3");

    // Scenario 4: stall on tid 3, then block the stalled tid.
    thread_en = 4'b1111;
    exp_q = {0, 1, 2, 0, 1, 2, 0};
    edges(5);
    fetch_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      edges(1);
      chk("s4 stall tid", int'(TID_fetch), 3);
      chk("s4 stall valid", int'(fetch_valid), 1);
    end
    block(3, 0);
    edges(1);
    block_valid = 1'b0;
    chk("s4 offer withdrawn", int'(fetch_valid), 0);
    edges(1);
    chk("s4 reoffer valid", int'(fetch_valid), 1);
    chk("s4 reoffer tid", int'(TID_fetch), 0);
    fetch_ready = 1'b1;
    edges(3);
    finish_scn("s4");

    // Scenario 5a: sparse enable, then everything disabled.
    thread_en = 4'b0101;
    exp_q = {0, 2, 0, 2};
    edges(5);
    thread_en = 4'b0000;
    edges(1);
    chk("s5a all disabled valid", int'(fetch_valid), 0);
    chk("s5a all disabled mask", int'(ready_mask), 0);
    edges(1);
    chk("s5a still idle", int'(fetch_valid), 0);
    finish_scn("s5a");

    // Scenario 5b: every enabled thread waiting.
    thread_en = 4'b0011;
    exp_q = {1};
    edges(1);
    block(0, 0);
    edges(1);
    block(1, 0);
    edges(1);
    block_valid = 1'b0;
    chk("s5b all waiting valid", int'(fetch_valid), 0);
    chk("s5b all waiting mask", int'(ready_mask), 0);
    edges(1);
    chk("s5b still idle", int'(fetch_valid), 0);
    finish_scn("s5b");

    // Scenario 6: asynchronous reset mid-stream, then restart.
    thread_en = 4'b1111;
    exp_q = {0, 1, 2};
    edges(5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("s6 async valid", int'(fetch_valid), 0);
    chk("s6 async tid", int'(TID_fetch), 0);
    chk("s6 async mask", int'(ready_mask), 0);
    chk("s6 first part drained", exp_q.size(), 0);
    exp_q = {0, 1, 2, 3};
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    edges(5);
    finish_scn("s6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
